// File: rtl/timer_prog_ctrl.sv
// timer_prog_ctrl: programmable hh:mm:ss countdown timer controller.
//   clk, reset                 : clock, synchronous active-high reset
//   tick_1hz                   : one-cycle pulse once per second
//   btn_prog/start/left/right/up/down : debounced one-cycle button pulses
//   okmaquina                  : display values valid (low only during reset)
//   programar_on               : high while in program mode
//   direccion_actual_pantalla  : selected field, 6 = hh, 7 = mm, 8 = ss
//   timer_in1/2/3              : packed BCD hours / minutes / seconds
//   alarm                      : countdown expired
// Every output comes straight from a flop, so a pulse sampled on one edge
// shows up on the outputs right after that edge.
module timer_prog_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_prog,
  input  logic       btn_start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       okmaquina,
  output logic       programar_on,
  output logic [3:0] direccion_actual_pantalla,
  output logic [7:0] timer_in1,
  output logic [7:0] timer_in2,
  output logic [7:0] timer_in3,
  output logic       alarm
);

  typedef enum logic [1:0] {IDLE, PROG, RUN, DONE} state_e;
  typedef enum logic [2:0] {B_NONE, B_PROG, B_START, B_RIGHT, B_LEFT, B_UP, B_DOWN} btn_e;

  localparam logic [3:0] DIR_HH = 4'd6;
  localparam logic [3:0] DIR_MM = 4'd7;
  localparam logic [3:0] DIR_SS = 4'd8;
  localparam logic [7:0] MAX_HH = 8'h23;
  localparam logic [7:0] MAX_MS = 8'h59;

  state_e     state_q, state_d;
  logic [7:0] hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [3:0] dir_q, dir_d;
  logic       prog_on_q, prog_on_d;
  logic       alarm_q, alarm_d;
  logic       ok_q, ok_d;
  btn_e       btn;
  logic [7:0] cd_hh, cd_mm, cd_ss;

  // BCD increment with wrap from max back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)             return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement with wrap from 00 up to max.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)           return max;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Only the highest-priority pulse is acted on; the rest are dropped even
  // when the winner turns out to be ignored in the current state.
  always_comb begin
    btn = B_NONE;
    if      (btn_prog)  btn = B_PROG;
    else if (btn_start) btn = B_START;
    else if (btn_right) btn = B_RIGHT;
    else if (btn_left)  btn = B_LEFT;
    else if (btn_up)    btn = B_UP;
    else if (btn_down)  btn = B_DOWN;
  end

  // One-second countdown with borrow ss -> mm -> hh. Only used in RUN, where
  // the value is never 00:00:00, so hours never underflow.
  always_comb begin
    cd_hh = hh_q;
    cd_mm = mm_q;
    cd_ss = ss_q;
    if (ss_q != 8'h00) begin
      cd_ss = bcd_dec(ss_q, MAX_MS);
    end else begin
      cd_ss = MAX_MS;
      if (mm_q != 8'h00) begin
        cd_mm = bcd_dec(mm_q, MAX_MS);
      end else begin
        cd_mm = MAX_MS;
        cd_hh = bcd_dec(hh_q, MAX_HH);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    dir_d     = dir_q;
    prog_on_d = prog_on_q;
    alarm_d   = alarm_q;
    ok_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (btn == B_PROG) begin
          state_d   = PROG;
          prog_on_d = 1'b1;
          dir_d     = DIR_HH;
        end else if (btn == B_START && {hh_q, mm_q, ss_q} != 24'h0) begin
          state_d = RUN;
        end
      end
      PROG: begin
        case (btn)
          B_PROG: begin
            state_d   = IDLE;
            prog_on_d = 1'b0;
          end
          B_RIGHT: dir_d = (dir_q == DIR_SS) ? DIR_HH : dir_q + 4'd1;
          B_LEFT:  dir_d = (dir_q == DIR_HH) ? DIR_SS : dir_q - 4'd1;
          B_UP: begin
            case (dir_q)
              DIR_HH:  hh_d = bcd_inc(hh_q, MAX_HH);
              DIR_MM:  mm_d = bcd_inc(mm_q, MAX_MS);
              default: ss_d = bcd_inc(ss_q, MAX_MS);
            endcase
          end
          B_DOWN: begin
            case (dir_q)
              DIR_HH:  hh_d = bcd_dec(hh_q, MAX_HH);
              DIR_MM:  mm_d = bcd_dec(mm_q, MAX_MS);
              default: ss_d = bcd_dec(ss_q, MAX_MS);
            endcase
          end
          default: ;
        endcase
      end
      RUN: begin
        // Pause wins over a coincident tick.
        if (btn == B_START) begin
          state_d = IDLE;
        end else if (tick_1hz) begin
          hh_d = cd_hh;
          mm_d = cd_mm;
          ss_d = cd_ss;
          if ({cd_hh, cd_mm, cd_ss} == 24'h0) begin
            state_d = DONE;
            alarm_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (btn == B_START || btn == B_PROG) begin
          state_d = IDLE;
          alarm_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hh_q      <= 8'h00;
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      dir_q     <= DIR_HH;
      prog_on_q <= 1'b0;
      alarm_q   <= 1'b0;
      ok_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      dir_q     <= dir_d;
      prog_on_q <= prog_on_d;
      alarm_q   <= alarm_d;
      ok_q      <= ok_d;
    end
  end

  assign okmaquina                 = ok_q;
  assign programar_on              = prog_on_q;
  assign direccion_actual_pantalla = dir_q;
  assign timer_in1                 = hh_q;
  assign timer_in2                 = mm_q;
  assign timer_in3                 = ss_q;
  assign alarm                     = alarm_q;

endmodule

// File: tb/tb_timer_prog_ctrl.sv
// Bench for timer_prog_ctrl: directed scenarios followed by random button and
// tick traffic, every cycle compared against a model that keeps the time as
// integer hours/minutes/seconds and a total-seconds countdown.
module tb_timer_prog_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick_1hz;
  logic       btn_prog, btn_start, btn_left, btn_right, btn_up, btn_down;
  logic       okmaquina, programar_on, alarm;
  logic [3:0] direccion_actual_pantalla;
  logic [7:0] timer_in1, timer_in2, timer_in3;

  int vectors = 0;
  int miscompares = 0;

  // model state: 0 idle, 1 program, 2 running, 3 expired
  int m_st, m_h, m_m, m_s, m_dir, m_ok;

  always #5 clk = ~clk;

  timer_prog_ctrl dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
    .btn_prog(btn_prog), .btn_start(btn_start), .btn_left(btn_left),
    .btn_right(btn_right), .btn_up(btn_up), .btn_down(btn_down),
    .okmaquina(okmaquina), .programar_on(programar_on),
    .direccion_actual_pantalla(direccion_actual_pantalla),
    .timer_in1(timer_in1), .timer_in2(timer_in2), .timer_in3(timer_in3),
    .alarm(alarm)
  );

  function automatic logic [7:0] to_bcd(input int n);
    return 8'(((n / 10) * 16) + (n % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, p, s, l, rt, u, d, t);
    int w, tot;
    if (r) begin
      m_st = 0; m_h = 0; m_m = 0; m_s = 0; m_dir = 6; m_ok = 0;
      return;
    end
    m_ok = 1;
    w = p ? 1 : s ? 2 : rt ? 3 : l ? 4 : u ? 5 : d ? 6 : 0;
    tot = m_h * 3600 + m_m * 60 + m_s;
    case (m_st)
      0: if (w == 1) begin m_st = 1; m_dir = 6; end
         else if (w == 2 && tot != 0) m_st = 2;
      1: case (w)
           1: m_st = 0;
           3: m_dir = (m_dir == 8) ? 6 : m_dir + 1;
           4: m_dir = (m_dir == 6) ? 8 : m_dir - 1;
           5: if (m_dir == 6) m_h = (m_h + 1) % 24;
              else if (m_dir == 7) m_m = (m_m + 1) % 60;
              else m_s = (m_s + 1) % 60;
           6: if (m_dir == 6) m_h = (m_h + 23) % 24;
              else if (m_dir == 7) m_m = (m_m + 59) % 60;
              else m_s = (m_s + 59) % 60;
           default: ;
         endcase
      2: if (w == 2) m_st = 0;
         else if (t) begin
           tot = tot - 1;
           m_h = tot / 3600; m_m = (tot / 60) % 60; m_s = tot % 60;
           if (tot == 0) m_st = 3;
         end
      default: if (w == 1 || w == 2) m_st = 0;
    endcase
  endtask

  // One clock: drive, advance model on the edge, compare just after it.
  task automatic cyc(input logic r, p, s, l, rt, u, d, t);
    reset = r; btn_prog = p; btn_start = s; btn_left = l;
    btn_right = rt; btn_up = u; btn_down = d; tick_1hz = t;
    @(posedge clk);
    model(r, p, s, l, rt, u, d, t);
    #1;
    chk("okmaquina", {7'd0, okmaquina}, 8'(m_ok));
    chk("programar_on", {7'd0, programar_on}, 8'(m_st == 1));
    chk("direccion", {4'd0, direccion_actual_pantalla}, 8'(m_dir));
    chk("timer_in1", timer_in1, to_bcd(m_h));
    chk("timer_in2", timer_in2, to_bcd(m_m));
    chk("timer_in3", timer_in3, to_bcd(m_s));
    chk("alarm", {7'd0, alarm}, 8'(m_st == 3));
    @(negedge clk);
  endtask

  // Single-control shorthands (args: reset prog start left right up down tick)
  task automatic idle(); cyc(0,0,0,0,0,0,0,0); endtask
  task automatic rst();  cyc(1,0,0,0,0,0,0,0); endtask
  task automatic prg();  cyc(0,1,0,0,0,0,0,0); endtask
  task automatic sta();  cyc(0,0,1,0,0,0,0,0); endtask
  task automatic rgt();  cyc(0,0,0,0,1,0,0,0); endtask
  task automatic up();   cyc(0,0,0,0,0,1,0,0); endtask
  task automatic dn();   cyc(0,0,0,0,0,0,1,0); endtask
  task automatic tck();  cyc(0,0,0,0,0,0,0,1); endtask

  initial begin
    // reset state and okmaquina release
    rst(); rst();
    chk("rst_ok", {7'd0, okmaquina}, 8'h00);
    chk("rst_dir", {4'd0, direccion_actual_pantalla}, 8'h06);
    idle();
    chk("ok_after_release", {7'd0, okmaquina}, 8'h01);

    // program hours to 03
    prg(); up(); up(); up();
    chk("hh_03", timer_in1, 8'h03);
    chk("prog_on", {7'd0, programar_on}, 8'h01);
    chk("dir_hh", {4'd0, direccion_actual_pantalla}, 8'h06);

    // minutes wrap both ways, direction wrap 8 -> 6
    rgt(); dn();
    chk("mm_wrap_down", timer_in2, 8'h59);
    up();
    chk("mm_wrap_up", timer_in2, 8'h00);
    rgt(); rgt();
    chk("dir_wrap", {4'd0, direccion_actual_pantalla}, 8'h06);

    // 01:00:00 -> one tick -> 00:59:59, then pause with coincident tick
    dn(); dn(); prg(); sta(); tck();
    chk("borrow_hh", timer_in1, 8'h00);
    chk("borrow_mm", timer_in2, 8'h59);
    chk("borrow_ss", timer_in3, 8'h59);
    cyc(0,0,1,0,0,0,0,1);
    chk("pause_ss", timer_in3, 8'h59);

    // 00:00:02 -> two ticks -> expired; extra tick ignored; start clears
    rst(); prg(); rgt(); rgt(); up(); up(); prg(); sta(); tck(); tck();
    chk("alarm_set", {7'd0, alarm}, 8'h01);
    tck();
    chk("done_ss", timer_in3, 8'h00);
    sta();
    chk("alarm_clr", {7'd0, alarm}, 8'h00);

    // start at zero ignored; prog+up together only enters program mode
    rst(); sta();
    chk("zero_start", {7'd0, programar_on}, 8'h00);
    cyc(0,1,0,0,0,1,0,0);
    chk("prog_up_hh", timer_in1, 8'h00);
    chk("prog_up_on", {7'd0, programar_on}, 8'h01);

    // reset mid-run at 00:10:05
    rgt(); repeat (10) up(); rgt(); repeat (5) up(); prg(); sta();
    chk("run_mm", timer_in2, 8'h10);
    rst();
    chk("midrun_rst_mm", timer_in2, 8'h00);
    chk("midrun_rst_ok", {7'd0, okmaquina}, 8'h00);
    idle();
    chk("midrun_release_ok", {7'd0, okmaquina}, 8'h01);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [5:0] b;
      int pick;
      logic t, r;
      pick = int'($urandom_range(0, 19));
      b = 6'd0;
      if (pick == 0) b = 6'($urandom_range(0, 63));
      else if (pick <= 12) b = 6'(1 << ((pick - 1) % 6));
      t = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 199) == 0);
      // bits: prog start left right up down
      cyc(r, b[0], b[1], b[2], b[3], b[4], b[5], t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_prog_ctrl.md
TIMER_PROG_CTRL -- requirements
Module: timer_prog_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port tick_1hz, input, 1, one-cycle pulse once per second.
REQ-004 SHALL have ports btn_prog, btn_start, btn_left, btn_right, btn_up, btn_down, input, 1 each, debounced one-cycle button pulses.
REQ-005 SHALL have port okmaquina, output, 1, high when the display values are valid.
REQ-006 SHALL have port programar_on, output, 1, high while in program mode.
REQ-007 SHALL have port direccion_actual_pantalla, output, 4, selected field: 6 = hours, 7 = minutes, 8 = seconds.
REQ-008 SHALL have ports timer_in1, timer_in2, timer_in3, output, 8 each, packed BCD hours, minutes and seconds (tens in [7:4], units in [3:0]).
REQ-009 SHALL have port alarm, output, 1, high when the countdown has expired.

Function
REQ-010 SHALL implement a state machine with states IDLE, PROG, RUN and DONE; all outputs registered.
REQ-011 SHALL act on at most one button per cycle, using fixed priority btn_prog > btn_start > btn_right > btn_left > btn_up > btn_down; lower-priority pulses in the same cycle are dropped.
REQ-012 IDLE: btn_prog -> PROG, programar_on=1, direccion=6.
REQ-013 IDLE: btn_start with time != 00:00:00 -> RUN; with time == 00:00:00, ignored and stays IDLE.
REQ-014 IDLE: tick_1hz ignored.
REQ-015 PROG: btn_right steps direccion 6->7->8->6; btn_left steps 8->7->6->8.
REQ-016 PROG: btn_up increments the selected field and btn_down decrements it; hours wrap 23<->00, minutes and seconds wrap 59<->00; BCD units roll 9->0 with carry into tens, and 0->9 with borrow.
REQ-017 PROG: btn_prog -> IDLE, programar_on=0 on the next cycle, direccion held.
REQ-018 PROG: btn_start and tick_1hz ignored.
REQ-019 RUN: each tick_1hz decrements hh:mm:ss by one second with BCD borrow chain ss->mm->hh (e.g. 01:00:00 -> 00:59:59).
REQ-020 RUN: a decrement whose result is 00:00:00 -> DONE, alarm=1 in the same update cycle.
REQ-021 RUN: btn_start -> IDLE (pause), value held; btn_start in the same cycle as tick_1hz pauses and suppresses that decrement.
REQ-022 RUN: btn_prog, arrow buttons, btn_up and btn_down ignored.
REQ-023 DONE: alarm held at 1, value held at 00:00:00, tick_1hz ignored.
REQ-024 DONE: btn_start or btn_prog -> IDLE, alarm=0; DONE never enters PROG directly.
REQ-025 Every BCD nibble output SHALL stay in 0..9 and every field within its legal range at all times.
REQ-026 okmaquina SHALL be 0 during reset and 1 from the first clock edge after reset deasserts, then stay 1.
REQ-027 Update latency SHALL be one clock: a pulse sampled at edge N is visible on the outputs after edge N.

Reset
REQ-028 Reset SHALL drive: state=IDLE, timer_in1=timer_in2=timer_in3=8'h00, direccion=6, programar_on=0, alarm=0, okmaquina=0.
REQ-029 Reset SHALL override all inputs, including mid-countdown and in DONE; the first post-reset cycle behaves as IDLE.

Verification
REQ-030 Reset, btn_prog, then btn_up x3 -> timer_in1=8'h03, programar_on=1, direccion=6.
REQ-031 PROG with minutes selected (direccion=7) at 00, btn_down -> timer_in2=8'h59; btn_up -> 8'h00; btn_right at direccion=8 -> 6.
REQ-032 Program 01:00:00, btn_prog, btn_start, one tick -> 00:59:59; btn_start together with tick_1hz -> IDLE with value unchanged.
REQ-033 Run from 00:00:02 with two ticks -> 00:00:00, state DONE, alarm=1; a further tick leaves it unchanged; btn_start -> alarm=0, IDLE.
REQ-034 btn_start at 00:00:00 in IDLE -> stays IDLE; btn_prog+btn_up in the same cycle -> PROG entered, value unchanged.
REQ-035 Reset asserted mid-RUN at 00:10:05 -> all outputs at the REQ-028 values one cycle later; okmaquina=1 one cycle after release.
